hdmi_qsys_pio_in: RTL and testbench

Parametrised Avalon-MM input PIO slave for the HDMI Qsys system, replacing fixed 1-bit status inputs such as the refresh flag. It provides a WIDTH-bit level read, per-bit edge capture with write-1-to-clear, and a per-bit interrupt mask. It drives one level-sensitive irq so the Nios II can wait on events such as refresh or vsync without polling.

---
 rtl/hdmi_qsys_pio_in.sv | 126 ++++++++++++
 tb/tb_hdmi_qsys_pio_in.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_qsys_pio_in.sv
// Avalon-MM input PIO: level read, per-bit edge capture, irq mask.
// Optional macro PIO_IN_SYNC_EN adds a 2-flop input synchroniser.
module hdmi_qsys_pio_in #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned EDGE_TYPE  = 1,
    parameter logic [31:0] RESET_MASK = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] mask;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             mask_wr;
    logic             cap_wr;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

`ifdef PIO_IN_SYNC_EN
    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;

    // Two-flop synchroniser for asynchronous inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= in_port;
            sync_q2 <= sync_q1;
        end
    end

    assign data_in = sync_q2;
`else
    assign data_in = in_port;
`endif

    assign wr_en   = chipselect & ~write_n;
    assign mask_wr = wr_en && (address == 2'd2);
    assign cap_wr  = wr_en && (address == 2'd3);

    // Previous level tracks input even in reset: no edge at release.
    always_ff @(posedge clk) begin
        prev <= data_in;
    end

    // Select which transitions count as events.
    always_comb begin
        rise     = data_in & ~prev;
        fall     = ~data_in & prev;
        edge_hit = '0;
        case (EDGE_TYPE)
            1:       edge_hit = rise;
            2:       edge_hit = fall;
            3:       edge_hit = rise | fall;
            default: edge_hit = '0;
        endcase
    end

    generate
        if (EDGE_TYPE == 0) begin : g_no_cap
            logic unused_cap;
            assign unused_cap = cap_wr ^ (|edge_hit);
            assign cap        = '0;
        end else begin : g_cap
            // Sticky capture; a new event beats a same-cycle clear.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cap <= '0;
                end else if (cap_wr) begin
                    cap <= (cap & ~writedata[WIDTH-1:0]) | edge_hit;
                end else begin
                    cap <= cap | edge_hit;
                end
            end
        end
    endgenerate

    // Interrupt mask register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= RESET_MASK[WIDTH-1:0];
        end else if (mask_wr) begin
            mask <= writedata[WIDTH-1:0];
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = data_in;
            2'd2:    rd_mux[WIDTH-1:0] = mask;
            2'd3:    rd_mux[WIDTH-1:0] = cap;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, sampled every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(cap & mask);

endmodule

// File: tb/tb_hdmi_qsys_pio_in.sv
// Bench for hdmi_qsys_pio_in: five configurations on a shared bus,
// directed steps then random traffic against a behavioural model.
module tb_hdmi_qsys_pio_in;

    localparam int N = 5;
    localparam int          W  [N] = '{8, 8, 8, 4, 1};
    localparam int          E  [N] = '{1, 2, 3, 0, 1};
    localparam logic [31:0] RM [N] = '{32'h0, 32'h0, 32'h0, 32'h5, 32'h0};

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] ins [N];
    logic [31:0] rd  [N];
    logic        irq [N];

    logic [31:0] m_cap  [N];
    logic [31:0] m_mask [N];
    logic [31:0] m_prev [N];
    logic [31:0] m_rd   [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hdmi_qsys_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .RESET_MASK(32'h0)) u0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(ins[0][7:0]),
        .readdata(rd[0]), .irq(irq[0]));
    hdmi_qsys_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .RESET_MASK(32'h0)) u1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(ins[1][7:0]),
        .readdata(rd[1]), .irq(irq[1]));
    hdmi_qsys_pio_in #(.WIDTH(8), .EDGE_TYPE(3), .RESET_MASK(32'h0)) u2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(ins[2][7:0]),
        .readdata(rd[2]), .irq(irq[2]));
    hdmi_qsys_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .RESET_MASK(32'h5)) u3 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(ins[3][3:0]),
        .readdata(rd[3]), .irq(irq[3]));
    hdmi_qsys_pio_in #(.WIDTH(1), .EDGE_TYPE(1), .RESET_MASK(32'h0)) u4 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(ins[4][0:0]),
        .readdata(rd[4]), .irq(irq[4]));

    function automatic logic [31:0] wmask(int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock from the register map rules, then
    // step the DUTs and compare every output.
    task automatic tick();
        for (int i = 0; i < N; i++) begin
            logic [31:0] din, rs, fl, ev, clr;
            din = ins[i] & wmask(W[i]);
            if (reset) begin
                m_rd[i]   = 0;
                m_cap[i]  = 0;
                m_mask[i] = RM[i] & wmask(W[i]);
            end else begin
                case (address)
                    2'd0: m_rd[i] = din;
                    2'd1: m_rd[i] = 0;
                    2'd2: m_rd[i] = m_mask[i];
                    default: m_rd[i] = m_cap[i];
                endcase
                rs = din & ~m_prev[i];
                fl = ~din & m_prev[i] & wmask(W[i]);
                ev = (E[i] == 1) ? rs : (E[i] == 2) ? fl :
                     (E[i] == 3) ? (rs | fl) : 32'h0;
                clr = (chipselect && !write_n && address == 2'd3) ?
                      (writedata & wmask(W[i])) : 32'h0;
                m_cap[i] = (m_cap[i] & ~clr) | ev;
                if (chipselect && !write_n && address == 2'd2)
                    m_mask[i] = writedata & wmask(W[i]);
            end
            m_prev[i] = din;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rd%0d", i), rd[i], m_rd[i]);
            chk($sformatf("irq%0d", i), {31'h0, irq[i]},
                {31'h0, |(m_cap[i] & m_mask[i])});
        end
    endtask

    task automatic bus(logic cs, logic wn, logic [1:0] a, logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ins[i]    = 0;
            m_cap[i]  = 0;
            m_mask[i] = 0;
            m_prev[i] = 0;
            m_rd[i]   = 0;
        end
        reset = 1'b1;
        bus(1'b0, 1'b1, 2'd0, 32'h0);
        #2;
        tick();
        tick();
        chk("reset_rd", rd[0], 32'h0);
        chk("reset_irq", {31'h0, irq[0]}, 32'h0);
        reset = 1'b0;

        // mask = 0x05 everywhere
        bus(1'b1, 1'b0, 2'd2, 32'h5);
        tick();
        bus(1'b0, 1'b1, 2'd3, 32'h0);

        // rising capture on u0
        ins[0] = 32'h01;
        tick();
        chk("irq_rise", {31'h0, irq[0]}, 32'h1);
        chk("cap_old", rd[0], 32'h0);
        tick();
        chk("cap_rise", rd[0], 32'h01);
        ins[0] = 32'h02;
        tick();
        tick();
        chk("cap_two", rd[0], 32'h03);
        chk("irq_hold", {31'h0, irq[0]}, 32'h1);
        bus(1'b1, 1'b0, 2'd3, 32'h1);
        tick();
        bus(1'b0, 1'b1, 2'd3, 32'h0);
        chk("irq_clr", {31'h0, irq[0]}, 32'h0);
        tick();
        chk("cap_clr", rd[0], 32'h02);

        // falling capture on u1
        ins[1] = 32'hFF;
        tick();
        ins[1] = 32'h7F;
        tick();
        tick();
        chk("cap_fall", rd[1], 32'h80);
        ins[1] = 32'hFF;
        tick();
        tick();
        chk("fall_ign_rise", rd[1], 32'h80);

        // set wins over clear on u2
        ins[2] = 32'h01;
        bus(1'b1, 1'b0, 2'd3, 32'h1);
        tick();
        bus(1'b0, 1'b1, 2'd3, 32'h0);
        chk("set_wins_irq", {31'h0, irq[2]}, 32'h1);
        tick();
        chk("set_wins", rd[2], 32'h01);

        // read-only data / direction registers
        ins[4] = 32'h1;
        bus(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF);
        tick();
        bus(1'b0, 1'b1, 2'd0, 32'h0);
        tick();
        chk("data_ro", rd[0], 32'h02);
        chk("w1_data", rd[4], 32'h1);
        bus(1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF);
        tick();
        bus(1'b0, 1'b1, 2'd1, 32'h0);
        tick();
        chk("dir_zero", rd[0], 32'h0);

        // mask readback width, u3 has no capture
        ins[3] = 32'hF;
        bus(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF);
        tick();
        bus(1'b0, 1'b1, 2'd2, 32'h0);
        tick();
        chk("mask_w4", rd[3], 32'hF);
        chk("mask_w8", rd[0], 32'hFF);
        chk("nocap_irq", {31'h0, irq[3]}, 32'h0);

        // reset mid-operation with input held high
        ins[0] = 32'h03;
        tick();
        chk("pre_rst_irq", {31'h0, irq[0]}, 32'h1);
        reset = 1'b1;
        ins[0] = 32'hFF;
        tick();
        tick();
        reset = 1'b0;
        bus(1'b0, 1'b1, 2'd3, 32'h0);
        tick();
        tick();
        chk("rst_cap", rd[0], 32'h0);
        chk("rst_irq", {31'h0, irq[0]}, 32'h0);
        bus(1'b0, 1'b1, 2'd2, 32'h0);
        tick();
        chk("rst_mask", rd[0], 32'h0);
        chk("rst_mask_u3", rd[3], 32'h5);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) ins[i] = $urandom;
            reset = ($urandom_range(0, 49) == 0);
            bus($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                2'($urandom_range(0, 3)), $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
